// File: rtl/processor_writeback_stage.sv
// rtl/processor_writeback_stage.sv - MEM/WB register, load extension, register-file write port, forwarding history, retire counter
// Optional feature macro: WB_SIGN_EXT_EN (sign-extending byte/halfword/word loads)
module processor_writeback_stage #(
  parameter int DATA_WIDTH     = 64,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int ZERO_REG       = 31,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      stall,
  input  logic                      flush,
  input  logic                      in_valid,
  input  logic                      in_RegWrite,
  input  logic [REG_ADDR_WIDTH-1:0] in_Rd,
  input  logic                      in_MemToReg,
  input  logic                      in_MOVcmd,
  input  logic [1:0]                in_MemSize,
  input  logic                      in_MemSigned,
  input  logic [DATA_WIDTH-1:0]     in_ALU,
  input  logic [DATA_WIDTH-1:0]     in_Dout,
  input  logic [DATA_WIDTH-1:0]     in_MOV,
  output logic                      wb_valid,
  output logic                      RegWrite_o,
  output logic [REG_ADDR_WIDTH-1:0] Rd_o,
  output logic [DATA_WIDTH-1:0]     WriteData_o,
  output logic                      fwd1_valid,
  output logic [REG_ADDR_WIDTH-1:0] fwd1_Rd,
  output logic [DATA_WIDTH-1:0]     fwd1_data,
  output logic [CNT_WIDTH-1:0]      retired_count
);

  localparam logic [REG_ADDR_WIDTH-1:0] ZERO_IDX = REG_ADDR_WIDTH'(ZERO_REG);
  localparam logic [DATA_WIDTH-1:0]     ONES     = '1;
  localparam int SH_BYTE = DATA_WIDTH - 8;
  localparam int SH_HALF = DATA_WIDTH - 16;
  localparam int SH_WORD = DATA_WIDTH - 32;

  logic                      valid_r;
  logic                      RegWrite_r;
  logic [REG_ADDR_WIDTH-1:0] Rd_r;
  logic                      MemToReg_r;
  logic                      MOVcmd_r;
  logic [1:0]                MemSize_r;
  logic                      MemSigned_r;
  logic [DATA_WIDTH-1:0]     ALU_r;
  logic [DATA_WIDTH-1:0]     Dout_r;
  logic [DATA_WIDTH-1:0]     MOV_r;

  logic [DATA_WIDTH-1:0]     low_mask;
  logic                      sign_bit;
  logic                      sign_fill;
  logic [DATA_WIDTH-1:0]     load_data;
  logic                      advance;

  // The stage moves forward unless held; a flush always moves it (retiring the resident instruction).
  assign advance = ~stall | flush;

  // Stage register: reset and flush both leave a fully zeroed bubble, stall holds, otherwise capture.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      valid_r     <= 1'b0;
      RegWrite_r  <= 1'b0;
      Rd_r        <= '0;
      MemToReg_r  <= 1'b0;
      MOVcmd_r    <= 1'b0;
      MemSize_r   <= 2'd0;
      MemSigned_r <= 1'b0;
      ALU_r       <= '0;
      Dout_r      <= '0;
      MOV_r       <= '0;
    end else if (!stall) begin
      valid_r     <= in_valid;
      RegWrite_r  <= in_RegWrite;
      Rd_r        <= in_Rd;
      MemToReg_r  <= in_MemToReg;
      MOVcmd_r    <= in_MOVcmd;
      MemSize_r   <= in_MemSize;
      MemSigned_r <= in_MemSigned;
      ALU_r       <= in_ALU;
      Dout_r      <= in_Dout;
      MOV_r       <= in_MOV;
    end
  end

  // Pick the kept low-bit mask and the sign bit for the load size; at DATA_WIDTH=32 the word mask is all ones.
  always_comb begin
    low_mask = ONES;
    sign_bit = 1'b0;
    case (MemSize_r)
      2'd1: begin
        low_mask = ONES >> SH_BYTE;
        sign_bit = Dout_r[7];
      end
      2'd2: begin
        low_mask = ONES >> SH_HALF;
        sign_bit = Dout_r[15];
      end
      2'd3: begin
        low_mask = ONES >> SH_WORD;
        sign_bit = Dout_r[31];
      end
      default: begin
        low_mask = ONES;
        sign_bit = 1'b0;
      end
    endcase
  end

`ifdef WB_SIGN_EXT_EN
  assign sign_fill = MemSigned_r & sign_bit;
`else
  // Loads are always zero-extended; the captured sign request is deliberately folded away.
  assign sign_fill = 1'b0 & MemSigned_r & sign_bit;
`endif

  // With a full-width load the inverted mask is zero, so the sign request has no effect.
  assign load_data = (Dout_r & low_mask) | (sign_fill ? ~low_mask : '0);

  // Write-data select: MOV result beats memory data, memory data beats the ALU result.
  always_comb begin
    WriteData_o = ALU_r;
    if (MOVcmd_r) begin
      WriteData_o = MOV_r;
    end else if (MemToReg_r) begin
      WriteData_o = load_data;
    end
  end

  assign wb_valid   = valid_r;
  assign Rd_o       = Rd_r;
  assign RegWrite_o = valid_r & RegWrite_r & (Rd_r != ZERO_IDX);

  // Retirement: a leaving real instruction is recorded in history and counted; a leaving bubble kills history.
  always_ff @(posedge clk) begin
    if (reset) begin
      fwd1_valid    <= 1'b0;
      fwd1_Rd       <= '0;
      fwd1_data     <= '0;
      retired_count <= '0;
    end else if (advance) begin
      if (valid_r) begin
        fwd1_valid    <= RegWrite_o;
        fwd1_Rd       <= Rd_o;
        fwd1_data     <= WriteData_o;
        retired_count <= retired_count + CNT_WIDTH'(1);
      end else begin
        fwd1_valid    <= 1'b0;
      end
    end
  end

endmodule

// File: doc/processor_writeback_stage.md
Name: processor_writeback_stage

Overview:
Parametrised write-back stage with its own MEM/WB pipeline register, stall/flush control and multi-size load extension. It sits between the memory stage and the register file. It drives the register-file write port and two forwarding taps: the current write-back and the previously retired write. It also keeps a retired-instruction counter for performance bring-up.

Parameters:
DATA_WIDTH, 64, datapath width; legal values are 32 and 64.
REG_ADDR_WIDTH, 5, register index width.
ZERO_REG, 31, register index whose writes are suppressed (XZR).
CNT_WIDTH, 32, retired-instruction counter width.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
stall  input  1  hold the stage register and history.
flush  input  1  load a bubble instead of the incoming instruction; has priority over stall.
in_valid  input  1  incoming instruction is real.
in_RegWrite  input  1  incoming instruction writes Rd.
in_Rd  input  REG_ADDR_WIDTH  destination register.
in_MemToReg  input  1  select memory data over ALU data.
in_MOVcmd  input  1  select MOV data; has priority over in_MemToReg.
in_MemSize  input  2  load size: 0 full width, 1 byte, 2 halfword, 3 word.
in_MemSigned  input  1  sign-extend the load; see Optional Feature.
in_ALU  input  DATA_WIDTH  ALU result.
in_Dout  input  DATA_WIDTH  data-memory read data.
in_MOV  input  DATA_WIDTH  MOVK/MOVZ merged value.
wb_valid  output  1  stage holds a real instruction.
RegWrite_o  output  1  register-file write enable.
Rd_o  output  REG_ADDR_WIDTH  register-file write address.
WriteData_o  output  DATA_WIDTH  register-file write data.
fwd1_valid  output  1  history entry is a live write.
fwd1_Rd  output  REG_ADDR_WIDTH  history destination register.
fwd1_data  output  DATA_WIDTH  history write data.
retired_count  output  CNT_WIDTH  number of retired instructions.

Behaviour:
Reset:
- On a reset edge, every register is cleared to 0.
- All outputs therefore read 0 the cycle after reset; the counter reads 0.
- Reset mid-operation discards the resident instruction and the history; the instruction is not counted.

Stage register:
- Edge with flush=1: stage gets valid=0 and control bits 0.
- Edge with stall=1, flush=0: stage holds.
- Otherwise: stage captures all in_* signals. Latency is exactly 1 cycle from inputs to outputs.

Write enable:
- RegWrite_o = valid_r & RegWrite_r & (Rd_r != ZERO_REG).
- Rd_o = Rd_r, driven even when RegWrite_o=0.
- While stalled, RegWrite_o repeats the same write each cycle (idempotent, allowed).

Data mux, combinational from the stage register:
- MOVcmd_r=1 selects MOV_r.
- Else MemToReg_r=1 selects the extended Dout_r.
- Else ALU_r is selected.

Load extension:
- Low 8/16/32 bits of Dout_r for sizes 1/2/3; size 0 passes the full width.
- Upper bits are zero-filled.
- When DATA_WIDTH=32, size 3 equals size 0.

Retirement:
- An instruction retires on an edge where (stall=0 or flush=1) and valid_r=1.
- On retirement: history gets {RegWrite_o, Rd_o, WriteData_o} and retired_count increments, wrapping mod 2^CNT_WIDTH.
- Edge where valid_r=0 and the stage is not held: history gets fwd1_valid=0; counter holds.
- Stall without flush: history and counter hold.
- Flush retires the resident instruction and kills only the incoming one.

Simultaneous events: reset > flush > stall.

Optional Feature:
Macro WB_SIGN_EXT_EN.
- Defined: when in_MemSigned=1 (captured into the stage) and size is 1/2/3, upper bits replicate bit 7/15/31 of Dout_r. With size 0, in_MemSigned is ignored.
- Undefined: in_MemSigned is ignored and loads are always zero-extended. The port remains so instantiations are unchanged.

Test Plan:
1. Reset held for 2 cycles, then released with idle inputs -> all outputs 0; retired_count=0.
2. Load, size 1, Dout=64'hFFEE_DDCC_BBAA_9985, Rd=3, RegWrite=1, MemToReg=1 -> next cycle RegWrite_o=1, Rd_o=3, WriteData_o=64'h85. With WB_SIGN_EXT_EN and MemSigned=1 -> 64'hFFFF_FFFF_FFFF_FF85.
3. MOVcmd=1, MemToReg=1, MOV=64'h1234, ALU=64'h5 -> WriteData_o=64'h1234. Then MOVcmd=0, MemToReg=0 -> 64'h5.
4. Write to Rd=31 with RegWrite=1, valid=1 -> RegWrite_o=0; the instruction still retires (counter +1) and fwd1_valid=0 the following cycle.
5. Issue A (Rd=4, data 7), then stall for 3 cycles while B (Rd=5) is presented, then release:
   - During the stall: outputs remain A; counter unchanged.
   - On release: fwd1 = {1,4,7}, stage = B, counter +1.
6. Flush and stall asserted together with C presented while A is resident -> A retires into history, stage becomes a bubble (wb_valid=0), and C never appears.
